// File: rtl/note_detector.sv
// Square-wave period meter and scale-note classifier (C4..C5).
// Rising edges are timed; a note is reported once MATCH_COUNT consecutive periods agree.
module note_detector #(
  parameter int CLK_HZ      = 25000000,
  parameter int CNT_W       = 20,
  parameter int TOL_SHIFT   = 6,
  parameter int MATCH_COUNT = 2,
  parameter int TIMEOUT     = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [2:0]       note_idx,
  output logic [7:0]       note_onehot,
  output logic [CNT_W-1:0] period_out,
  output logic             period_strobe
);

  typedef enum logic {IDLE, MEASURE} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       CNT_MAX = '1;
  localparam cnt_t       TO_CNT  = cnt_t'(TIMEOUT);
  localparam logic [3:0] MC      = 4'(MATCH_COUNT);

  function automatic int nom_period(input int i);
    int f;
    case (i)
      0:       f = 262;
      1:       f = 294;
      2:       f = 330;
      3:       f = 349;
      4:       f = 392;
      5:       f = 440;
      6:       f = 494;
      default: f = 523;
    endcase
    return 2 * ((CLK_HZ / f / 2) + 1);
  endfunction

  logic       sync1_q, sync2_q, hist_q;
  logic       edge_ev;
  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d, elapsed;
  cnt_t       period_q, period_d;
  logic       strobe_q, strobe_d;
  logic       valid_q, valid_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] match_q, match_d;
  logic       prev_ok_q, prev_ok_d;
  logic [2:0] prev_idx_q, prev_idx_d;
  logic [7:0] hit;
  logic       cand_ok;
  logic [2:0] cand_idx;

  assign edge_ev = sync2_q & ~hist_q;

  // cnt_q is cleared on an edge, so cycles since that edge is cnt_q + 1.
  assign elapsed = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);

  for (genvar g = 0; g < 8; g++) begin : g_win
    localparam int   PN  = nom_period(g);
    localparam int   TOL = PN >> TOL_SHIFT;
    localparam cnt_t LO  = cnt_t'(PN - TOL);
    localparam cnt_t HI  = cnt_t'(PN + TOL);
    assign hit[g] = (elapsed >= LO) && (elapsed <= HI);
  end

  always_comb begin
    cand_ok  = |hit;
    cand_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (hit[i]) cand_idx = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    strobe_d   = 1'b0;
    valid_d    = valid_q;
    idx_d      = idx_q;
    match_d    = match_q;
    prev_ok_d  = prev_ok_q;
    prev_idx_d = prev_idx_q;
    case (state_q)
      IDLE: begin
        if (edge_ev) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_ev) begin
          cnt_d    = '0;
          period_d = elapsed;
          strobe_d = 1'b1;
          if (!cand_ok) begin
            valid_d = 1'b0;
            match_d = '0;
          end else if (prev_ok_q && (cand_idx == prev_idx_q)) begin
            match_d = (match_q >= MC) ? MC : match_q + 4'd1;
          end else begin
            match_d = 4'd1;
            valid_d = 1'b0;
          end
          prev_ok_d  = cand_ok;
          prev_idx_d = cand_idx;
          if (cand_ok && (match_d == MC)) begin
            valid_d = 1'b1;
            idx_d   = cand_idx;
          end
        end else if (elapsed >= TO_CNT) begin
          // Silence: forget the previous candidate so a new tone must re-qualify.
          state_d   = IDLE;
          valid_d   = 1'b0;
          match_d   = '0;
          prev_ok_d = 1'b0;
        end else begin
          cnt_d = elapsed;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      strobe_q   <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      match_q    <= '0;
      prev_ok_q  <= 1'b0;
      prev_idx_q <= '0;
    end else begin
      sync1_q    <= tone_in;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      strobe_q   <= strobe_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      prev_ok_q  <= prev_ok_d;
      prev_idx_q <= prev_idx_d;
    end
  end

  assign note_valid    = valid_q;
  assign note_idx      = idx_q;
  assign note_onehot   = valid_q ? (8'h80 >> idx_q) : 8'h00;
  assign period_out    = period_q;
  assign period_strobe = strobe_q;

endmodule
